// File: rtl/enigma_stepper_core.sv
`default_nettype none
// ============================================================================
//  Module   : enigma_stepper_core
//  Function : Sequential N-rotor Enigma engine with odometer stepping, a
//             valid/ready letter input and a one-cycle ciphertext pulse.
//             Define ENIGMA_DOUBLE_STEP_EN for the historical double-step.
//  Revision : 1.0 - initial release
// ============================================================================
module enigma_stepper_core #(
  parameter int                      NUM_ROTORS = 3,
  parameter int                      ALPHA      = 26,
  parameter int                      NOTCH      = 25,
  parameter logic [5*NUM_ROTORS-1:0] RING       = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [5*NUM_ROTORS-1:0]   pos_load,
  input  logic                      in_valid,
  input  logic [4:0]                in_char,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [4:0]                out_char,
  output logic                      err,
  output logic [5*NUM_ROTORS-1:0]   pos_out
);

  localparam int c_LW = 5;
  localparam int c_SW = $clog2(NUM_ROTORS * (ALPHA - 1) + 1);
  localparam int c_OW = $clog2(3 * ALPHA);
`ifdef ENIGMA_DOUBLE_STEP_EN
  localparam bit c_DOUBLE = 1'b1;
`else
  localparam bit c_DOUBLE = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_SUM  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t                               state_q, state_d;
  logic [NUM_ROTORS-1:0][c_LW-1:0]      pos_q, pos_d;
  logic [c_LW-1:0]                      x_q, x_d;
  logic [c_SW-1:0]                      sum_q, sum_d;
  logic [c_LW-1:0]                      out_char_q, out_char_d;
  logic                                 out_valid_q, out_valid_d;
  logic                                 err_q, err_d;

  logic [NUM_ROTORS-1:0]                w_step;
  logic [NUM_ROTORS-1:0]                w_at_notch;
  logic [NUM_ROTORS-1:0][c_LW-1:0]      w_pos_inc;
  logic [NUM_ROTORS-1:0][c_LW-1:0]      w_load_mod;
  logic [NUM_ROTORS-1:0][c_LW-1:0]      w_term;
  logic [c_SW-1:0]                      w_sum;
  logic [c_LW-1:0]                      w_s_mod;
  logic [c_OW-1:0]                      w_val;
  logic [c_LW-1:0]                      w_cipher;
  logic                                 w_bad_char;

  // Per-rotor helpers: increment with wrap, notch detect, ring-offset term.
  for (genvar i = 0; i < NUM_ROTORS; i++) begin : g_rotor
    logic [c_LW:0] w_raw;
    assign w_at_notch[i] = (pos_q[i] == c_LW'(NOTCH));
    assign w_pos_inc[i]  = (pos_q[i] == c_LW'(ALPHA - 1)) ? '0 : pos_q[i] + c_LW'(1);
    assign w_load_mod[i] = c_LW'(32'(pos_load[c_LW*i +: c_LW]) % 32'(ALPHA));
    assign w_raw         = {1'b0, pos_q[i]} + {1'b0, RING[c_LW*i +: c_LW]};
    assign w_term[i]     = (w_raw >= (c_LW+1)'(ALPHA)) ? c_LW'(w_raw - (c_LW+1)'(ALPHA))
                                                        : w_raw[c_LW-1:0];
  end

  // Step carry ripples from rotor 0 using pre-step positions.
  always_comb begin
    w_step    = '0;
    w_step[0] = 1'b1;
    for (int i = 1; i < NUM_ROTORS; i++) begin
      w_step[i] = w_step[i-1] & w_at_notch[i-1];
      if (c_DOUBLE && (i < NUM_ROTORS - 1) && w_at_notch[i]) begin
        w_step[i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_ROTORS; i++) begin
      w_sum = w_sum + c_SW'(w_term[i]);
    end
  end

  // (ALPHA-1 - x - 2S) mod ALPHA, biased by 2*ALPHA so the value stays in [0, 3*ALPHA).
  assign w_s_mod  = c_LW'(32'(sum_q) % 32'(ALPHA));
  assign w_val    = c_OW'(ALPHA - 1) - c_OW'(x_q) + c_OW'(2 * ALPHA) - c_OW'({w_s_mod, 1'b0});
  assign w_cipher = (w_val >= c_OW'(2 * ALPHA)) ? c_LW'(w_val - c_OW'(2 * ALPHA)) :
                    (w_val >= c_OW'(ALPHA))     ? c_LW'(w_val - c_OW'(ALPHA))     :
                                                  c_LW'(w_val);

  assign w_bad_char = ({1'b0, in_char} >= (c_LW+1)'(ALPHA));
  assign in_ready   = (state_q == S_IDLE) && !load;

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    x_d         = x_q;
    sum_d       = sum_q;
    out_char_d  = out_char_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          pos_d = w_load_mod;
        end else if (in_valid) begin
          x_d = in_char;
          if (w_bad_char) begin
            err_d = 1'b1;
          end else begin
            state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        for (int i = 0; i < NUM_ROTORS; i++) begin
          if (w_step[i]) begin
            pos_d[i] = w_pos_inc[i];
          end
        end
        state_d = S_SUM;
      end
      S_SUM: begin
        sum_d   = w_sum;
        state_d = S_OUT;
      end
      S_OUT: begin
        out_char_d  = w_cipher;
        out_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pos_q       <= '0;
      x_q         <= '0;
      sum_q       <= '0;
      out_char_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      x_q         <= x_d;
      sum_q       <= sum_d;
      out_char_q  <= out_char_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign err       = err_q;
  assign pos_out   = pos_q;

endmodule
`default_nettype wire

// File: tb/tb_enigma_stepper_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_enigma_stepper_core
//  Function : Scoreboard bench for enigma_stepper_core (N=3, ALPHA=26).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_enigma_stepper_core;

`ifdef ENIGMA_DOUBLE_STEP_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        load;
  logic [14:0] pos_load;
  logic        in_valid;
  logic [4:0]  in_char;
  logic        in_ready;
  logic        out_valid;
  logic [4:0]  out_char;
  logic        err;
  logic [14:0] pos_out;

  typedef struct packed {
    logic [4:0]  ch;
    logic [14:0] pos;
  } exp_t;

  exp_t sb[$];
  int   m_pos[3];
  int   n_pass;
  int   n_total;

  enigma_stepper_core #(
    .NUM_ROTORS(3),
    .ALPHA     (26),
    .NOTCH     (25),
    .RING      (15'd0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .pos_load (pos_load),
    .in_valid (in_valid),
    .in_char  (in_char),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_char (out_char),
    .err      (err),
    .pos_out  (pos_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [14:0] m_pack();
    return {5'(m_pos[2]), 5'(m_pos[1]), 5'(m_pos[0])};
  endfunction

  function automatic void m_step();
    bit st[3];
    st[0] = 1'b1;
    for (int i = 1; i < 3; i++) begin
      st[i] = st[i-1] && (m_pos[i-1] == 25);
      if (DS && i == 1 && m_pos[1] == 25) st[i] = 1'b1;
    end
    for (int i = 0; i < 3; i++) if (st[i]) m_pos[i] = (m_pos[i] + 1) % 26;
  endfunction

  function automatic int m_cipher(input int x);
    int s, v;
    s = m_pos[0] + m_pos[1] + m_pos[2];
    v = 25 - x - 2 * s;
    return ((v % 26) + 26) % 26;
  endfunction

  function automatic exp_t pop_exp();
    exp_t e;
    e.ch  = 5'd31;
    e.pos = 15'h7fff;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic load_pos(input int p2, input int p1, input int p0);
    @(negedge clk);
    load     = 1'b1;
    pos_load = {5'(p2), 5'(p1), 5'(p0)};
    @(posedge clk);
    #1 load = 1'b0;
    m_pos[0] = p0 % 26;
    m_pos[1] = p1 % 26;
    m_pos[2] = p2 % 26;
  endtask

  task automatic accept(input int x);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = 5'(x);
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (x < 26) begin
      m_step();
      e.ch  = 5'(m_cipher(x));
      e.pos = m_pack();
      sb.push_back(e);
    end
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_pos = '{0, 0, 0};
    sb.delete();
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else n_pass++;
    n_total++; if (out_char !== 5'd0) $display("FAIL reset_out_char: got %0d expected 0", out_char); else n_pass++;
    n_total++; if (pos_out !== 15'd0) $display("FAIL reset_pos: got %h expected 0", pos_out); else n_pass++;
  endtask

  task automatic test_basic();
    int   lat;
    exp_t e;
    accept(0);
    wait_out(lat);
    e = pop_exp();
    n_total++; if (lat !== 3) $display("FAIL basic_latency: got %0d expected 3", lat); else n_pass++;
    n_total++; if (out_char !== 5'd23) $display("FAIL basic_char: got %0d expected 23", out_char); else n_pass++;
    n_total++; if (out_char !== e.ch) $display("FAIL basic_char_sb: got %0d expected %0d", out_char, e.ch); else n_pass++;
    n_total++; if (pos_out !== {5'd0, 5'd0, 5'd1}) $display("FAIL basic_pos: got %h expected %h", pos_out, {5'd0, 5'd0, 5'd1}); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL basic_pulse_width: got %b expected 0", out_valid); else n_pass++;
    n_total++; if (out_char !== 5'd23) $display("FAIL basic_char_hold: got %0d expected 23", out_char); else n_pass++;
  endtask

  task automatic test_cascade();
    int   lat;
    exp_t e;
    load_pos(0, 0, 25);
    accept(0);
    wait_out(lat);
    e = pop_exp();
    n_total++; if (pos_out !== {5'd0, 5'd1, 5'd0}) $display("FAIL cascade_pos: got %h expected %h", pos_out, {5'd0, 5'd1, 5'd0}); else n_pass++;
    n_total++; if (out_char !== e.ch) $display("FAIL cascade_char: got %0d expected %0d", out_char, e.ch); else n_pass++;
    load_pos(25, 25, 25);
    accept(7);
    wait_out(lat);
    e = pop_exp();
    n_total++; if (pos_out !== e.pos) $display("FAIL wrap_all_pos: got %h expected %h", pos_out, e.pos); else n_pass++;
    n_total++; if (out_char !== e.ch) $display("FAIL wrap_all_char: got %0d expected %0d", out_char, e.ch); else n_pass++;
  endtask

  task automatic test_double_step();
    int          lat;
    exp_t        e;
    logic [14:0] exp_pos;
    logic [4:0]  exp_ch;
    exp_pos = DS ? {5'd1, 5'd0, 5'd25} : {5'd0, 5'd25, 5'd25};
    exp_ch  = DS ? 5'd25 : 5'd3;
    load_pos(0, 25, 24);
    accept(0);
    wait_out(lat);
    e = pop_exp();
    n_total++; if (pos_out !== exp_pos) $display("FAIL dstep_pos: got %h expected %h", pos_out, exp_pos); else n_pass++;
    n_total++; if (out_char !== exp_ch) $display("FAIL dstep_char: got %0d expected %0d", out_char, exp_ch); else n_pass++;
    n_total++; if (out_char !== e.ch) $display("FAIL dstep_char_sb: got %0d expected %0d", out_char, e.ch); else n_pass++;
  endtask

  task automatic test_err();
    int lat;
    load_pos(3, 7, 11);
    for (int k = 0; k < 2; k++) begin
      accept(k == 0 ? 27 : 26);
      n_total++; if (err !== 1'b1) $display("FAIL err_pulse: got %b expected 1", err); else n_pass++;
      n_total++; if (in_ready !== 1'b1) $display("FAIL err_in_ready: got %b expected 1", in_ready); else n_pass++;
      @(posedge clk);
      #1;
      n_total++; if (err !== 1'b0) $display("FAIL err_width: got %b expected 0", err); else n_pass++;
      wait_out(lat);
      n_total++; if (lat !== -1) $display("FAIL err_no_out: got out_valid at %0d expected none", lat); else n_pass++;
      n_total++; if (pos_out !== m_pack()) $display("FAIL err_pos: got %h expected %h", pos_out, m_pack()); else n_pass++;
    end
  endtask

  task automatic test_load_priority();
    int lat;
    @(negedge clk);
    load     = 1'b1;
    in_valid = 1'b1;
    in_char  = 5'd5;
    pos_load = {5'd30, 5'd4, 5'd6};
    #1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL load_in_ready: got %b expected 0", in_ready); else n_pass++;
    @(posedge clk);
    #1;
    load     = 1'b0;
    in_valid = 1'b0;
    m_pos    = '{6, 4, 4};
    n_total++; if (pos_out !== m_pack()) $display("FAIL load_pos: got %h expected %h", pos_out, m_pack()); else n_pass++;
    wait_out(lat);
    n_total++; if (lat !== -1) $display("FAIL load_drop: got out_valid at %0d expected none", lat); else n_pass++;
  endtask

  task automatic test_reciprocal();
    int         lat;
    exp_t       e;
    logic [4:0] y;
    for (int x = 0; x < 26; x++) begin
      load_pos(21, 13, 7);
      accept(x);
      wait_out(lat);
      e = pop_exp();
      y = out_char;
      n_total++; if (y !== e.ch) $display("FAIL recip_fwd x=%0d: got %0d expected %0d", x, y, e.ch); else n_pass++;
      n_total++; if (y === 5'(x)) $display("FAIL recip_fixed x=%0d: got %0d expected any other letter", x, y); else n_pass++;
      load_pos(21, 13, 7);
      accept(int'(y));
      wait_out(lat);
      e = pop_exp();
      n_total++; if (out_char !== 5'(x)) $display("FAIL recip_back x=%0d: got %0d expected %0d", x, out_char, x); else n_pass++;
    end
  endtask

  task automatic test_rst_mid();
    int lat;
    load_pos(1, 2, 3);
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = 5'd4;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_pos = '{0, 0, 0};
    n_total++; if (pos_out !== 15'd0) $display("FAIL rstmid_pos: got %h expected 0", pos_out); else n_pass++;
    wait_out(lat);
    n_total++; if (lat !== -1) $display("FAIL rstmid_no_out: got out_valid at %0d expected none", lat); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int   seq[6] = '{0, 25, 13, 1, 24, 9};
    int   lat;
    bit   busy_ok;
    exp_t e;
    load_pos(0, 24, 23);
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = 5'(seq[0]);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      m_step();
      e.ch  = 5'(m_cipher(seq[k]));
      e.pos = m_pack();
      sb.push_back(e);
      if (k < 5) in_char = 5'(seq[k+1]);
      else       in_valid = 1'b0;
      lat     = -1;
      busy_ok = 1'b1;
      for (int c = 1; c <= 8; c++) begin
        @(posedge clk);
        #1;
        if (c < 3 && in_ready !== 1'b0) busy_ok = 1'b0;
        if (out_valid === 1'b1) begin
          lat = c;
          break;
        end
      end
      e = pop_exp();
      n_total++; if (lat !== 3) $display("FAIL b2b_latency k=%0d: got %0d expected 3", k, lat); else n_pass++;
      n_total++; if (busy_ok !== 1'b1) $display("FAIL b2b_busy k=%0d: got in_ready high while busy expected low", k); else n_pass++;
      n_total++; if (out_char !== e.ch) $display("FAIL b2b_char k=%0d: got %0d expected %0d", k, out_char, e.ch); else n_pass++;
      n_total++; if (pos_out !== e.pos) $display("FAIL b2b_pos k=%0d: got %h expected %h", k, pos_out, e.pos); else n_pass++;
    end
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    rst      = 1'b1;
    load     = 1'b0;
    pos_load = '0;
    in_valid = 1'b0;
    in_char  = '0;
    test_reset();
    test_basic();
    test_cascade();
    test_double_step();
    test_err();
    test_load_priority();
    test_reciprocal();
    test_rst_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
